// File: rtl/sad_window_writer_pkg.sv
// Shared constants, FSM encoding and element indexing for the SAD window writer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sad_window_writer_pkg;

    localparam int DATA_W = 32;
    localparam int WIN    = 4;
    localparam int ADDR_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        WRITE = 2'b01,
        DONE  = 2'b10
    } wrState_t;

    // Row-major position of a window element.
    function automatic int unsigned idx(input int unsigned row, input int unsigned col);
        return row * WIN + col;
    endfunction

endpackage

// File: rtl/sad_window_addr_gen.sv
// Row/col walker for a WIN x WIN window: word-aligned byte address, element index, last flag.
// Latency: new position visible the cycle after load/advance; outputs derive from registers only.
// Backpressure: position holds whenever advance is low.
module sad_window_addr_gen #(
    parameter int WIN    = 4,
    parameter int ADDR_W = 32,
    localparam int CNT_W = $clog2(WIN),
    localparam int IDX_W = $clog2(WIN * WIN)
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              load,
    input  logic              advance,
    input  logic [ADDR_W-1:0] baseAddr,
    input  logic [ADDR_W-1:0] rowSkip,
    output logic [ADDR_W-1:0] memAddr,
    output logic [IDX_W-1:0]  elemIdx,
    output logic              last
);
    import sad_window_writer_pkg::*;

    localparam logic [CNT_W-1:0] LAST_POS = CNT_W'(WIN - 1);

    logic [CNT_W-1:0]  row;
    logic [CNT_W-1:0]  col;
    logic [ADDR_W-1:0] rowBase;
    logic [ADDR_W-1:0] skipBytes;

    // Walk columns within a row, then step rowBase by the pitch; sums wrap modulo 2^ADDR_W.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            row       <= '0;
            col       <= '0;
            rowBase   <= '0;
            skipBytes <= '0;
        end else if (load) begin
            row       <= '0;
            col       <= '0;
            rowBase   <= baseAddr & ~ADDR_W'(3);
            skipBytes <= rowSkip << 2;
        end else if (advance) begin
            if (col == LAST_POS) begin
                col <= '0;
                if (row != LAST_POS) begin
                    row     <= row + CNT_W'(1);
                    rowBase <= rowBase + skipBytes;
                end
            end else begin
                col <= col + CNT_W'(1);
            end
        end
    end

    assign memAddr = rowBase + ADDR_W'({col, 2'b00});
    assign elemIdx = IDX_W'(idx(32'(row), 32'(col)));
    assign last    = (row == LAST_POS) && (col == LAST_POS);

endmodule

// File: rtl/sad_window_writer.sv
// Stores a latched WIN x WIN window to data memory as WIN*WIN single-word writes, row-major.
// Latency: Start at edge 0 -> writes in cycles 1..16 (MemReady high) -> Done pulse in cycle 17.
// Backpressure: MemWrite && !MemReady holds address, data and counters; Start ignored while busy.
module sad_window_writer #(
    parameter int DATA_W = sad_window_writer_pkg::DATA_W,
    parameter int WIN    = sad_window_writer_pkg::WIN,
    parameter int ADDR_W = sad_window_writer_pkg::ADDR_W
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic                      Start,
    input  logic [ADDR_W-1:0]         BaseAddr,
    input  logic [ADDR_W-1:0]         RowSkip,
    input  logic [WIN*WIN*DATA_W-1:0] WinData,
    output logic                      Busy,
    output logic                      Done,
    output logic                      MemWrite,
    output logic [ADDR_W-1:0]         MemAddr,
    output logic [DATA_W-1:0]         MemWriteData,
    input  logic                      MemReady
);
    import sad_window_writer_pkg::*;

    localparam int NUM   = WIN * WIN;
    localparam int IDX_W = $clog2(NUM);

    wrState_t          state;
    wrState_t          nextState;
    logic              load;
    logic              advance;
    logic              last;
    logic [IDX_W-1:0]  elemIdx;
    logic [DATA_W-1:0] winReg [NUM];

    sad_window_addr_gen #(
        .WIN    (WIN),
        .ADDR_W (ADDR_W)
    ) u_addrGen (
        .Clk      (Clk),
        .Reset    (Reset),
        .load     (load),
        .advance  (advance),
        .baseAddr (BaseAddr),
        .rowSkip  (RowSkip),
        .memAddr  (MemAddr),
        .elemIdx  (elemIdx),
        .last     (last)
    );

    // State register; reset aborts any transfer in flight without a Done pulse.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next state plus the load/advance strobes for the address walker.
    always_comb begin
        nextState = state;
        load      = 1'b0;
        advance   = 1'b0;
        case (state)
            IDLE: begin
                if (Start) begin
                    load      = 1'b1;
                    nextState = WRITE;
                end
            end
            WRITE: begin
                if (MemReady) begin
                    advance = 1'b1;
                    if (last) begin
                        nextState = DONE;
                    end
                end
            end
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Capture the whole window at acceptance so later input changes cannot leak in.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            for (int k = 0; k < NUM; k++) begin
                winReg[k] <= '0;
            end
        end else if (load) begin
            for (int k = 0; k < NUM; k++) begin
                winReg[k] <= WinData[k*DATA_W +: DATA_W];
            end
        end
    end

    assign MemWrite     = (state == WRITE);
    assign Busy         = (state == WRITE);
    assign Done         = (state == DONE);
    assign MemWriteData = winReg[elemIdx];

endmodule

// File: tb/tb_sad_window_writer.sv
module tb_sad_window_writer;
    localparam int DATA_W = 32;
    localparam int NUM    = 16;

    logic              Clk = 1'b0;
    logic              Reset;
    logic              Start;
    logic [31:0]       BaseAddr;
    logic [31:0]       RowSkip;
    logic [NUM*32-1:0] WinData;
    logic              Busy;
    logic              Done;
    logic              MemWrite;
    logic [31:0]       MemAddr;
    logic [31:0]       MemWriteData;
    logic              MemReady;

    int compared   = 0;
    int mismatched = 0;

    logic [63:0] expQ[$];
    int          doneExp      = 0;
    int          totalAccepts = 0;
    int          acceptBase   = 0;
    int          readyMode    = 0;
    int          stallLeft    = 0;
    logic [31:0] memModel [logic [31:0]];
    bit          holdValid    = 1'b0;
    logic [31:0] holdAddr;
    logic [31:0] holdData;

    sad_window_writer dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .Start        (Start),
        .BaseAddr     (BaseAddr),
        .RowSkip      (RowSkip),
        .WinData      (WinData),
        .Busy         (Busy),
        .Done         (Done),
        .MemWrite     (MemWrite),
        .MemAddr      (MemAddr),
        .MemWriteData (MemWriteData),
        .MemReady     (MemReady)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference: element (r,c) lands at the aligned base plus r rows of pitch plus c words.
    function automatic logic [31:0] refAddr(input logic [31:0] base, input logic [31:0] skip,
                                            input int r, input int c);
        logic [31:0] aligned;
        aligned = base - (base % 32'd4);
        return aligned + 32'(r) * skip * 32'd4 + 32'(c) * 32'd4;
    endfunction

    // Memory-port ready: always, random, or a 3-cycle stall on element 5.
    initial begin
        MemReady = 1'b1;
        forever begin
            @(posedge Clk);
            #1;
            case (readyMode)
                1:       MemReady = ($urandom_range(0, 3) != 0);
                2: begin
                    if ((totalAccepts - acceptBase) == 5 && stallLeft > 0) begin
                        MemReady  = 1'b0;
                        stallLeft = stallLeft - 1;
                    end else begin
                        MemReady = 1'b1;
                    end
                end
                default: MemReady = 1'b1;
            endcase
        end
    end

    // Monitor: pops the scoreboard on every accepted write, checks stall stability and Done.
    initial begin
        forever begin
            @(negedge Clk);
            if (Reset === 1'b1 && MemWrite === 1'b1) begin
                if (holdValid) begin
                    chk("hold_addr", MemAddr, holdAddr);
                    chk("hold_data", MemWriteData, holdData);
                end
                if (MemReady) begin
                    if (expQ.size() == 0) begin
                        chk("unexpected_write", 1, 0);
                    end else begin
                        logic [63:0] e;
                        e = expQ.pop_front();
                        chk("write_addr", MemAddr, e[63:32]);
                        chk("write_data", MemWriteData, e[31:0]);
                    end
                    memModel[MemAddr] = MemWriteData;
                    totalAccepts++;
                    holdValid = 1'b0;
                end else begin
                    holdValid = 1'b1;
                    holdAddr  = MemAddr;
                    holdData  = MemWriteData;
                end
            end else begin
                holdValid = 1'b0;
            end
            if (Done === 1'b1) begin
                if (doneExp == 0) chk("spurious_done", 1, 0);
                else doneExp--;
            end
        end
    end

    task automatic runWindow(input logic [31:0] base, input logic [31:0] skip, input bit seqData,
                             input int mode, input int pulseAt, input int resetAfter,
                             output int doneCycle, output int busyCycles);
        logic [NUM*32-1:0] d;
        int n;
        for (int k = 0; k < NUM; k++) begin
            d[k*32 +: 32] = seqData ? 32'(k + 1) : $urandom();
        end
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                expQ.push_back({refAddr(base, skip, r, c), d[(r*4+c)*32 +: 32]});
            end
        end
        doneExp++;
        readyMode  = mode;
        stallLeft  = 3;
        acceptBase = totalAccepts;
        @(posedge Clk);
        #1;
        Start = 1'b1; BaseAddr = base; RowSkip = skip; WinData = d;
        @(posedge Clk);
        #1;
        Start = 1'b0; BaseAddr = $urandom(); RowSkip = $urandom(); WinData = {16{$urandom()}};
        n = 0; doneCycle = -1; busyCycles = 0;
        while (n < 400) begin
            @(negedge Clk);
            #1;
            n++;
            if (Busy) busyCycles++;
            if (pulseAt > 0 && n == pulseAt) begin
                Start = 1'b1; BaseAddr = 32'h400;
            end else if (pulseAt > 0 && n == pulseAt + 1) begin
                Start = 1'b0;
            end
            if (resetAfter > 0 && (totalAccepts - acceptBase) == resetAfter) begin
                @(posedge Clk);
                #1;
                Reset = 1'b0;
                #1;
                chk("rst_mid_memwrite", MemWrite, 0);
                chk("rst_mid_busy", Busy, 0);
                expQ.delete();
                doneExp--;
                @(negedge Clk);
                chk("rst_mid_done", Done, 0);
                chk("rst_mid_addr", MemAddr, 0);
                chk("rst_mid_data", MemWriteData, 0);
                Reset = 1'b1;
                doneCycle = -2;
                break;
            end
            if (Done) begin
                doneCycle = n;
                break;
            end
        end
        if (doneCycle == -1) chk("done_timeout", 1, 0);
    endtask

    task automatic endCheck(input string name);
        chk({name, "_pending_writes"}, expQ.size(), 0);
        chk({name, "_pending_done"}, doneExp, 0);
    endtask

    initial begin
        int dc;
        int bc;
        Reset = 1'b0; Start = 1'b0; BaseAddr = '0; RowSkip = '0; WinData = '0;
        #3;
        chk("reset_busy", Busy, 0);
        chk("reset_done", Done, 0);
        chk("reset_memwrite", MemWrite, 0);
        chk("reset_addr", MemAddr, 0);
        chk("reset_data", MemWriteData, 0);
        repeat (2) @(negedge Clk);
        Reset = 1'b1;

        runWindow(32'h100, 32'd8, 1'b1, 0, 0, 0, dc, bc);
        chk("basic_done_cycle", dc, 17);
        chk("basic_busy_cycles", bc, 16);
        endCheck("basic");

        runWindow(32'h100, 32'd8, 1'b0, 0, 0, 0, dc, bc);
        chk("back_to_back_done_cycle", dc, 17);
        endCheck("back_to_back");

        runWindow(32'h100, 32'd8, 1'b1, 2, 0, 0, dc, bc);
        chk("stall_done_cycle", dc, 20);
        endCheck("stall");

        runWindow(32'hFFFF_FFF3, 32'd4, 1'b0, 0, 0, 0, dc, bc);
        chk("wrap_done_cycle", dc, 17);
        endCheck("wrap");

        runWindow(32'h100, 32'd8, 1'b0, 0, 7, 0, dc, bc);
        chk("start_busy_done_cycle", dc, 17);
        repeat (5) @(negedge Clk);
        chk("start_busy_idle", Busy, 0);
        endCheck("start_busy");

        runWindow(32'h100, 32'd8, 1'b0, 0, 0, 9, dc, bc);
        chk("reset_abort", dc, -2);
        repeat (4) @(negedge Clk);
        endCheck("reset_abort");
        runWindow(32'h300, 32'd8, 1'b1, 0, 0, 0, dc, bc);
        chk("after_reset_done_cycle", dc, 17);
        endCheck("after_reset");

        memModel.delete();
        runWindow(32'h200, 32'd0, 1'b1, 0, 0, 0, dc, bc);
        endCheck("skip0");
        for (int c = 0; c < 4; c++) begin
            chk("skip0_mem", memModel.exists(32'h200 + 32'(c*4)) ? memModel[32'h200 + 32'(c*4)] : 32'hDEAD,
                32'(13 + c));
        end

        for (int t = 0; t < 6; t++) begin
            runWindow($urandom(), 32'($urandom_range(0, 64)), 1'b0, 1, 0, 0, dc, bc);
            chk("rand_done_seen", dc > 0, 1);
            endCheck("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
